// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: next-hop codes, flit fields, FSM states.
// Used by every input port and the per-output rr processors.
package noc_pkg;

   localparam logic [2:0] NH_N    = 3'd0;
   localparam logic [2:0] NH_S    = 3'd1;
   localparam logic [2:0] NH_W    = 3'd2;
   localparam logic [2:0] NH_E    = 3'd3;
   localparam logic [2:0] NH_L    = 3'd4;
   localparam logic [2:0] NH_NONE = 3'd7;

   typedef enum logic [1:0] {
      FT_BODY   = 2'b00,
      FT_TAIL   = 2'b01,
      FT_HEAD   = 2'b10,
      FT_SINGLE = 2'b11
   } flit_type_t;

   localparam int TYPE_W  = 2;
   localparam int COORD_W = 3;
   // field offsets counted down from the flit MSB
   localparam int DX_OFF  = 2;
   localparam int DY_OFF  = 5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ROUTE,
      S_ACTIVE,
      S_DRAIN
   } state_t;

   function automatic logic is_head(flit_type_t t);
      return (t == FT_HEAD) || (t == FT_SINGLE);
   endfunction

   function automatic logic is_last(flit_type_t t);
      return (t == FT_TAIL) || (t == FT_SINGLE);
   endfunction

endpackage

// File: rtl/flit_fifo.sv
// Flit buffer with same-cycle push/pop; head is read combinationally.
// A push on full is accepted only when a pop frees the slot that cycle.
module flit_fifo #(
   parameter int DEPTH  = 4,
   parameter int FLIT_W = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [FLIT_W-1:0]        data_i,
   input  logic                     pop_i,
   output logic [FLIT_W-1:0]        head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [FLIT_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [AW:0]       r_count;
   logic              w_push;
   logic              w_pop;

   assign empty_o = (r_count == '0);
   assign full_o  = (r_count == FULL_CNT);
   assign count_o = r_count;
   assign head_o  = r_mem[r_rptr];

   assign w_pop  = pop_i && !empty_o;
   assign w_push = push_i && (!full_o || w_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + {{AW{1'b0}}, w_push}
                            - {{AW{1'b0}}, w_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr] <= data_i;
   end

endmodule

// File: rtl/w_input_port.sv
// West input port: buffers flits, XY-routes each head, requests an output
// and dequeues on the matching grant, returning one credit per pop.
module w_input_port
   import noc_pkg::*;
#(
   parameter int X_ID   = 0,
   parameter int Y_ID   = 0,
   parameter int DEPTH  = 4,
   parameter int FLIT_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FLIT_W-1:0] w_flit_i,
   input  logic              w_flit_valid_i,
   output logic              w_credit_o,
   output logic [2:0]        w_nexthop_addr_o,
   input  logic              n_grant_i,
   input  logic              s_grant_i,
   input  logic              e_grant_i,
   input  logic              l_grant_i,
   output logic [FLIT_W-1:0] flit_o,
   output logic              flit_valid_o,
   output logic              change_order_o,
   output logic              err_o
);

   localparam logic [COORD_W-1:0] MY_X = COORD_W'(X_ID);
   localparam logic [COORD_W-1:0] MY_Y = COORD_W'(Y_ID);

   logic [FLIT_W-1:0]        w_head;
   logic                     w_full;
   logic                     w_empty;
   logic [$clog2(DEPTH):0]   w_count;
   logic                     w_unused_cnt;
   flit_type_t               w_type;
   logic [COORD_W-1:0]       w_dx;
   logic [COORD_W-1:0]       w_dy;
   logic [2:0]               w_route_calc;
   logic                     w_uturn;
   state_t                   r_state;
   state_t                   w_cur;
   state_t                   w_next;
   logic [2:0]               r_route;
   logic [2:0]               w_nh;
   logic                     w_pop;
   logic                     w_xfer;
   logic                     w_fsm_err;
   logic [3:0]               w_gvec;
   logic [3:0]               w_gexp;
   logic                     w_gsel;
   logic                     w_bad_grant;
   logic                     w_drop;
   logic                     r_credit;
   logic                     r_err;

   flit_fifo #(
      .DEPTH  (DEPTH),
      .FLIT_W (FLIT_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (w_flit_valid_i),
      .data_i  (w_flit_i),
      .pop_i   (w_pop),
      .head_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (w_count)
   );

   assign w_unused_cnt = ^w_count;

   assign w_type = flit_type_t'(w_head[FLIT_W-1 -: TYPE_W]);
   assign w_dx   = w_head[FLIT_W-1-DX_OFF -: COORD_W];
   assign w_dy   = w_head[FLIT_W-1-DY_OFF -: COORD_W];

   always_comb begin
      w_route_calc = NH_L;
      w_uturn      = 1'b0;
      if (w_dx > MY_X)
         w_route_calc = NH_E;
      else if (w_dx < MY_X) begin
         w_route_calc = NH_NONE;
         w_uturn      = 1'b1;
      end else if (w_dy > MY_Y)
         w_route_calc = NH_S;
      else if (w_dy < MY_Y)
         w_route_calc = NH_N;
   end

   // a head reaching the FIFO head is routed in that same cycle
   always_comb begin
      w_cur = r_state;
      if (r_state == S_IDLE && !w_empty && is_head(w_type))
         w_cur = S_ROUTE;
   end

   always_comb begin
      w_next    = r_state;
      w_pop     = 1'b0;
      w_xfer    = 1'b0;
      w_nh      = NH_NONE;
      w_fsm_err = 1'b0;
      unique case (w_cur)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop     = 1'b1;
               w_fsm_err = 1'b1;
            end
         end
         S_ROUTE: begin
            w_next    = w_uturn ? S_DRAIN : S_ACTIVE;
            w_fsm_err = w_uturn;
         end
         S_ACTIVE: begin
            if (!w_empty) begin
               w_nh = r_route;
               if (w_gsel) begin
                  w_pop  = 1'b1;
                  w_xfer = 1'b1;
                  if (is_last(w_type))
                     w_next = S_IDLE;
               end
            end
         end
         S_DRAIN: begin
            if (!w_empty) begin
               w_pop = 1'b1;
               if (is_last(w_type))
                  w_next = S_IDLE;
            end
         end
         default: ;
      endcase
   end

   assign w_gvec = {n_grant_i, s_grant_i, e_grant_i, l_grant_i};

   always_comb begin
      w_gexp = 4'b0000;
      case (r_route)
         NH_N:    w_gexp = 4'b1000;
         NH_S:    w_gexp = 4'b0100;
         NH_E:    w_gexp = 4'b0010;
         NH_L:    w_gexp = 4'b0001;
         default: w_gexp = 4'b0000;
      endcase
   end

   assign w_gsel      = |(w_gvec & w_gexp);
   assign w_bad_grant = (w_cur == S_ACTIVE) ? |(w_gvec & ~w_gexp)
                                            : |w_gvec;
   assign w_drop      = w_flit_valid_i && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_route  <= NH_NONE;
         r_credit <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_next;
         if (w_cur == S_ROUTE)
            r_route <= w_route_calc;
         r_credit <= w_pop;
         if (w_fsm_err || w_bad_grant || w_drop)
            r_err <= 1'b1;
      end
   end

   assign w_nexthop_addr_o = w_nh;
   assign flit_valid_o     = w_xfer;
   assign flit_o           = w_xfer ? w_head : '0;
   assign change_order_o   = w_xfer && is_last(w_type);
   assign w_credit_o       = r_credit;
   assign err_o            = r_err;

endmodule
